// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the seven-segment display monitor.
// Segment patterns are active-low, bit0 = segment a through bit6 = segment g.
package seg7_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // IDLE: no reference digit held; TRACK: digit_q is the reference for sequencing.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Bundle of the observed segment bus and the monitor's decoded/status outputs.
// seg_in has no handshake: it is sampled every cycle; the pulse outputs are one-cycle strobes.
interface seg7_if #(
  parameter int ERR_CNT_W = 8
);
  import seg7_pkg::*;

  logic [6:0]           seg_in;
  logic [3:0]           digit;
  logic                 digit_valid;
  logic                 blank;
  logic                 new_digit;
  logic                 wrap;
  logic                 decode_err;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;
  state_t               state_dbg;

  modport master (
    output seg_in,
    input  digit, digit_valid, blank, new_digit, wrap,
    input  decode_err, seq_err, err_count, state_dbg
  );

  modport slave (
    input  seg_in,
    output digit, digit_valid, blank, new_digit, wrap,
    output decode_err, seq_err, err_count, state_dbg
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational pattern decoder: valid=1 for digits 0..9, blank=1 for all-off,
// both low for any other (illegal) pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (seg_i)
      SEG_0:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd0};
      SEG_1:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd1};
      SEG_2:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd2};
      SEG_3:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd3};
      SEG_4:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd4};
      SEG_5:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd5};
      SEG_6:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd6};
      SEG_7:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd7};
      SEG_8:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd8};
      SEG_9:     dec_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd9};
      SEG_BLANK: dec_o = '{valid: 1'b0, blank: 1'b1, digit: 4'd0};
      default:   dec_o = '0;
    endcase
  end

endmodule

// File: rtl/seg7_monitor.sv
// Watches an asynchronous seven-segment bus, qualifies stable patterns and
// reports decoded digits, sequence/decode errors and a saturating error count.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int ERR_CNT_W     = 8
) (
  input  logic  clock,
  input  logic  reset,
  seg7_if.slave bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  logic [6:0]           sync1_q, seg_s_q, last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [3:0]           digit_q, digit_d;
  logic                 dv_q, dv_d;
  logic                 blank_q, blank_d;
  logic                 nd_q, nd_d;
  logic                 wrap_q, wrap_d;
  logic                 de_q, de_d;
  logic                 se_q, se_d;
  logic [ERR_CNT_W-1:0] ec_q, ec_d;
  logic                 accept;
  dec_t                 dec;

  seg7_decode u_decode (
    .seg_i (seg_s_q),
    .dec_o (dec)
  );

  // cnt_q is the number of cycles seg_s_q has held its current value, counting
  // the cycle it arrived as 1; comparing against sync1_q keeps latency minimal.
  always_comb begin
    if (sync1_q != seg_s_q) begin
      cnt_d = 4'd1;
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign accept = (cnt_q == STABLE_C) && (seg_s_q != last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    digit_d = digit_q;
    dv_d    = dv_q;
    blank_d = blank_q;
    nd_d    = 1'b0;
    wrap_d  = 1'b0;
    de_d    = 1'b0;
    se_d    = 1'b0;
    ec_d    = ec_q;
    if (accept) begin
      last_d = seg_s_q;
      if (dec.valid) begin
        nd_d    = 1'b1;
        digit_d = dec.digit;
        dv_d    = 1'b1;
        blank_d = 1'b0;
        state_d = ST_TRACK;
        if (state_q == ST_TRACK) begin
          se_d   = (dec.digit != next_digit(digit_q));
          wrap_d = (dec.digit == 4'd0) && (digit_q == 4'd9);
        end
      end else if (dec.blank) begin
        blank_d = 1'b1;
        dv_d    = 1'b0;
        state_d = ST_IDLE;
      end else begin
        de_d    = 1'b1;
        dv_d    = 1'b0;
        blank_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
    if ((de_d || se_d) && (ec_q != '1)) begin
      ec_d = ec_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= SEG_BLANK;
      seg_s_q <= SEG_BLANK;
      last_q  <= SEG_BLANK;
      cnt_q   <= 4'd0;
      state_q <= ST_IDLE;
      digit_q <= 4'd0;
      dv_q    <= 1'b0;
      blank_q <= 1'b0;
      nd_q    <= 1'b0;
      wrap_q  <= 1'b0;
      de_q    <= 1'b0;
      se_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      sync1_q <= bus.seg_in;
      seg_s_q <= sync1_q;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      blank_q <= blank_d;
      nd_q    <= nd_d;
      wrap_q  <= wrap_d;
      de_q    <= de_d;
      se_q    <= se_d;
      ec_q    <= ec_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = dv_q;
  assign bus.blank       = blank_q;
  assign bus.new_digit   = nd_q;
  assign bus.wrap        = wrap_q;
  assign bus.decode_err  = de_q;
  assign bus.seq_err     = se_q;
  assign bus.err_count   = ec_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_seg7_monitor;
  import seg7_pkg::*;

  localparam int OUT_W = 18;

  logic clock;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nd_cnt  = 0;
  int   wrap_cnt = 0;
  int   se_cnt  = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] cur;
  logic [OUT_W-1:0] exp_w;
  logic [13:0]      prev_lv;
  logic [6:0]       pat_tab [10];

  seg7_if #(.ERR_CNT_W(8)) io ();

  seg7_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (io)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] watchdog FAIL got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] mk(input logic nd, input logic wr, input logic de,
                                          input logic se, input int dg, input logic dv,
                                          input logic bl, input int ec);
    return {nd, wr, de, se, 4'(dg), dv, bl, 8'(ec)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] %s FAIL got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_digit"}, 32'(io.digit), 0);
    check({tag, "_dv"}, 32'(io.digit_valid), 0);
    check({tag, "_blank"}, 32'(io.blank), 0);
    check({tag, "_nd"}, 32'(io.new_digit), 0);
    check({tag, "_wrap"}, 32'(io.wrap), 0);
    check({tag, "_derr"}, 32'(io.decode_err), 0);
    check({tag, "_serr"}, 32'(io.seq_err), 0);
    check({tag, "_ecnt"}, 32'(io.err_count), 0);
    check({tag, "_state"}, 32'(io.state_dbg), 32'(ST_IDLE));
  endtask

  // driver tasks: a pattern driven by step() is present for n full cycles
  task automatic step(input logic [6:0] pat, input int n);
    @(negedge clock);
    io.seg_in = pat;
    repeat (n - 1) @(negedge clock);
  endtask

  // Called right after seg_in changes on a negedge; the next posedge is edge 1.
  task automatic wait_nd(input string name, input int exp_edges);
    int  edges = 0;
    bit  seen  = 0;
    while (!seen && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (io.new_digit) seen = 1;
    end
    check(name, seen ? 32'(edges) : 32'd999, 32'(exp_edges));
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    cur = {io.new_digit, io.wrap, io.decode_err, io.seq_err, io.digit,
           io.digit_valid, io.blank, io.err_count};
    if (reset) begin
      prev_lv = cur[13:0];
    end else begin
      if (cur[17:14] != 4'b0 || cur[13:0] != prev_lv) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] sb_unexpected FAIL got %0h expected no event", cur);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_event", 32'(cur), 32'(exp_w));
        end
        if (cur[17]) nd_cnt++;
        if (cur[16]) wrap_cnt++;
        if (cur[14]) se_cnt++;
      end
      prev_lv = cur[13:0];
    end
  end

  initial begin
    pat_tab[0] = 7'h40; pat_tab[1] = 7'h79; pat_tab[2] = 7'h24; pat_tab[3] = 7'h30;
    pat_tab[4] = 7'h19; pat_tab[5] = 7'h12; pat_tab[6] = 7'h02; pat_tab[7] = 7'h78;
    pat_tab[8] = 7'h00; pat_tab[9] = 7'h18;

    reset     = 1'b1;
    io.seg_in = 7'h7F;
    repeat (3) @(negedge clock);
    check_reset("rst");
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check_reset("idle_blank");

    // counting sequence 0..9 then 0, first digit also checks latency
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clock);
    io.seg_in = pat_tab[0];
    wait_nd("lat_first", 6);
    repeat (4) @(negedge clock);
    for (int d = 1; d < 10; d++) begin
      exp_q.push_back(mk(1, 0, 0, 0, d, 1, 0, 0));
      step(pat_tab[d], 10);
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    step(pat_tab[0], 10);
    check("count_new_digit", 32'(nd_cnt), 11);
    check("count_wrap", 32'(wrap_cnt), 1);
    check("count_seq_err", 32'(se_cnt), 0);
    check("count_ecnt", 32'(io.err_count), 0);
    check("track_state", 32'(io.state_dbg), 32'(ST_TRACK));

    // blank, then 3 -> 5 sequence error
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    step(7'h7F, 10);
    check("blank_state", 32'(io.state_dbg), 32'(ST_IDLE));
    exp_q.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0));
    step(7'h30, 10);
    exp_q.push_back(mk(1, 0, 0, 1, 5, 1, 0, 1));
    step(7'h12, 10);
    check("seq_err_count", 32'(se_cnt), 1);

    // illegal pattern, then 2 with no sequence check
    exp_q.push_back(mk(0, 0, 1, 0, 5, 0, 0, 2));
    step(7'h7E, 10);
    check("derr_state", 32'(io.state_dbg), 32'(ST_IDLE));
    exp_q.push_back(mk(1, 0, 0, 0, 2, 1, 0, 2));
    step(7'h24, 10);

    // blank, then 0 with a 3-cycle glitch of 8 that must be ignored
    exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 1, 2));
    step(7'h7F, 10);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));
    step(7'h40, 10);
    step(7'h00, 3);
    step(7'h40, 10);
    check("glitch_digit", 32'(io.digit), 0);
    check("glitch_nd_total", 32'(nd_cnt), 15);

    // 300 illegal acceptances saturate the error counter
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, (2 + i > 255) ? 255 : 2 + i));
      step((i % 2 == 1) ? 7'h7E : 7'h7D, 6);
    end
    repeat (4) @(negedge clock);
    check("ecnt_saturated", 32'(io.err_count), 255);

    exp_q.push_back(mk(1, 0, 0, 0, 2, 1, 0, 255));
    step(7'h24, 10);

    // reset two cycles into qualification of 1
    step(7'h79, 2);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset("mid_rst");
    repeat (2) @(negedge clock);
    exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    reset = 1'b0;
    wait_nd("lat_after_rst", 6);
    repeat (6) @(negedge clock);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_monitor.md
SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive synchronized cycles a pattern must hold before acceptance; legal range 1..15.
REQ-002 Parameter ERR_CNT_W, default 8: error counter width.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 seg_in  input  7  observed segment bus, active-low, bit0=a ... bit6=g; asynchronous to clock.
REQ-006 digit  output  4  last accepted decoded BCD digit.
REQ-007 digit_valid  output  1  high while digit holds a valid decode.
REQ-008 blank  output  1  high while the accepted pattern is 7'h7F (all segments off).
REQ-009 new_digit  output  1  one-cycle pulse on each accepted valid digit.
REQ-010 wrap  output  1  one-cycle pulse, coincident with new_digit, when the accepted digit is 0 and the previous digit was 9.
REQ-011 decode_err  output  1  one-cycle pulse on acceptance of an illegal pattern.
REQ-012 seq_err  output  1  one-cycle pulse on acceptance of a valid digit that is not previous+1 mod 10.
REQ-013 err_count  output  ERR_CNT_W  saturating count of decode_err plus seq_err events.

Function
REQ-014 seg_in SHALL pass through a 2-flop synchronizer; its output is seg_s.
REQ-015 The stability counter SHALL load 1 when seg_s differs from its previous-cycle value, increment when equal, and saturate at STABLE_CYCLES.
REQ-016 Acceptance SHALL occur when the counter equals STABLE_CYCLES and seg_s differs from the last accepted pattern; each distinct stable pattern is accepted exactly once.
REQ-017 Latency: counting the first edge at which seg_in carries a new stable value as edge 1, the outputs SHALL update on edge STABLE_CYCLES+2.
REQ-018 Legal patterns SHALL be 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h18, blank=7'h7F; all other patterns are illegal.
REQ-019 The FSM SHALL have two states. IDLE means there is no reference digit. TRACK means a reference digit is held.
REQ-020 In IDLE, acceptance of a valid digit SHALL pulse new_digit, set digit and digit_valid, and move the FSM to TRACK with no sequence check.
REQ-021 In TRACK, acceptance of a valid digit SHALL pulse new_digit, and SHALL pulse seq_err if the digit is not (previous+1) mod 10; the FSM stays in TRACK and the new digit becomes the reference.
REQ-022 Acceptance of an illegal pattern SHALL pulse decode_err, clear digit_valid, hold digit, and move the FSM to IDLE.
REQ-023 Acceptance of blank SHALL set blank, clear digit_valid, raise no error, and move the FSM to IDLE; blank SHALL clear on the next accepted non-blank pattern.
REQ-024 decode_err and seq_err SHALL be mutually exclusive; err_count SHALL increment by at most 1 per acceptance and SHALL saturate at all-ones.
REQ-025 A pattern held for fewer than STABLE_CYCLES synchronized cycles SHALL produce no output change.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset SHALL force digit=0, digit_valid=0, blank=0, all pulse outputs=0, err_count=0, the FSM to IDLE, the stability counter to 0, the synchronizer flops to 7'h7F, and the last accepted pattern to 7'h7F.
REQ-028 Reset asserted mid-qualification SHALL discard the pending pattern; after release, a pattern is accepted only after a full qualification period.

Structure
REQ-029 Package seg7_pkg SHALL hold the eleven pattern constants, the FSM state enum, and the default STABLE_CYCLES value.
REQ-030 Sub-module seg7_decode SHALL be a purely combinational 7-bit to {valid, blank, digit[3:0]} decoder, instantiated once.

Verification
REQ-031 Drive patterns 0..9 then 0, each held 10 cycles -> 11 new_digit pulses, one wrap pulse on the final 0, seq_err never asserted, err_count=0.
REQ-032 Drive 7'h30 then 7'h12 (3 then 5) -> seq_err pulses once with digit=5, err_count=1.
REQ-033 Drive 7'h7E held 10 cycles -> decode_err pulses, digit_valid=0; then drive 7'h24 -> new_digit with digit=2 and no seq_err.
REQ-034 Drive a 3-cycle glitch of 7'h00 between stable 7'h40 periods with STABLE_CYCLES=4 -> no output change.
REQ-035 Produce 300 illegal pattern acceptances with ERR_CNT_W=8 -> err_count holds at 255.
REQ-036 Assert reset two cycles after seg_in changes to 7'h79 -> all outputs return to reset values, and new_digit fires only STABLE_CYCLES+2 edges after release.
